// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard (device-side) transmitter: 8x8 scan-code FIFO feeding an
// 11-bit frame serializer (start, d0..d7, odd parity, stop) clocked by a
// half-bit tick `ce`.
// Optional host-inhibit handling is compiled in with `PS2_TX_INHIBIT_EN`.
module ps2_kbd_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] din,
  input  logic       wr,
  output logic       full,
  output logic       ovf,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_data,
  input  logic       ps2_clk_in
);

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned AW        = 3;
  localparam int unsigned CW        = 4;
  localparam int unsigned FW        = 11;
  localparam int unsigned GAP_TICKS = 4;

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP, RETRY} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  state_t        state;
  logic [3:0]    idx;
  logic [FW-1:0] shreg;
  logic [7:0]    hold;
  logic [1:0]    gap_cnt;
  logic          line_ok;

  // Frame LSB first: start 0, data, odd parity, stop 1.
  function automatic logic [FW-1:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

`ifdef PS2_TX_INHIBIT_EN
  logic [1:0] clk_sync;

  // Two-flop synchronizer for the sensed bus clock; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) clk_sync <= 2'b11;
    else       clk_sync <= {clk_sync[0], ps2_clk_in};
  end

  assign line_ok = clk_sync[1];
`else
  logic unused_ps2_clk_in;
  assign unused_ps2_clk_in = ps2_clk_in;
  assign line_ok = 1'b1;
`endif

  // A pop is the IDLE->SETUP start of a frame; a push may ride along when full.
  assign pop  = (state == IDLE) && ce && (count != CW'(0)) && line_ok;
  assign push = wr && ((count != CW'(DEPTH)) || pop);

  // Next occupancy; simultaneous push and pop cancel.
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      ovf   <= wr && !push;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
    end
  end

  // Frame serializer; every step is gated by the half-bit tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      shreg    <= '0;
      hold     <= '0;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (pop) begin
            hold     <= mem[rptr];
            shreg    <= make_frame(mem[rptr]);
            idx      <= '0;
            ps2_data <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (!line_ok) begin
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            state    <= RETRY;
          end else begin
            ps2_clk <= 1'b0;
            state   <= LOW;
          end
        end
        LOW: begin
          ps2_clk <= 1'b1;
          if (idx < 4'(FW - 1)) begin
            idx      <= idx + 4'd1;
            ps2_data <= shreg[1];
            shreg    <= shreg >> 1;
            state    <= HIGH;
          end else begin
            ps2_data <= 1'b1;
            gap_cnt  <= '0;
            state    <= GAP;
          end
        end
        HIGH: begin
          if (!line_ok && (idx < 4'(FW - 1))) begin
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            state    <= RETRY;
          end else begin
            ps2_clk <= 1'b0;
            state   <= LOW;
          end
        end
        GAP: begin
          if (gap_cnt == 2'(GAP_TICKS - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 2'd1;
          end
        end
        RETRY: begin
          // Resend the held byte once the host releases the clock.
          if (line_ok) begin
            shreg    <= make_frame(hold);
            idx      <= '0;
            ps2_data <= 1'b0;
            state    <= SETUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
